// File: rtl/tmp_resp_pkg.sv
// Shared definitions for the temperature-sensor I2C responder.
//   tmp_state_e  : protocol FSM states
//   REG_*        : register map addresses
//   DEFAULT_ADDR : 7-bit bus address used when DEV_ADDR is not overridden
package tmp_resp_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6
  } tmp_state_e;

  localparam logic [7:0] REG_TMSB = 8'h00;
  localparam logic [7:0] REG_TLSB = 8'h01;
  localparam logic [7:0] REG_STAT = 8'h02;
  localparam logic [7:0] REG_CFG  = 8'h03;
  localparam logic [7:0] REG_ID   = 8'h0B;

  localparam logic [6:0] DEFAULT_ADDR = 7'h4B;

endpackage

// File: rtl/tmp_i2c_responder_sync_edge.sv
// i2c_sync_edge: 2-FF synchronizers for SCL/SDA plus edge and START/STOP detection.
// Ports:
//   clk, rst         : system clock, async active-high reset (flops reset to 1 = idle bus)
//   scl_i, sda_i     : raw bus inputs
//   sda_o            : synchronized SDA
//   scl_rise_o/fall_o: single-cycle SCL edge strobes
//   start_o, stop_o  : single-cycle START / STOP strobes
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic scl_meta_q, scl_sync_q, scl_prev_q;
  logic sda_meta_q, sda_sync_q, sda_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_prev_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_prev_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_prev_q <= sda_sync_q;
    end
  end

  assign sda_o      = sda_sync_q;
  assign scl_rise_o = scl_sync_q & ~scl_prev_q;
  assign scl_fall_o = ~scl_sync_q & scl_prev_q;
  // SDA transitions are only START/STOP when SCL is stably high across both samples.
  assign start_o    = scl_sync_q & scl_prev_q & sda_prev_q & ~sda_sync_q;
  assign stop_o     = scl_sync_q & scl_prev_q & ~sda_prev_q & sda_sync_q;

endmodule

// File: rtl/tmp_i2c_responder.sv
// tmp_i2c_responder: I2C target emulating a simple temperature sensor.
// Optional feature macro: TMP_RESP_STRETCH_EN (SCL stretching after each read-byte ACK).
// Parameters: DEV_ADDR (7-bit address), ID_VAL (register 0x0B), STRETCH_CYC (stretch length).
// Ports:
//   clk, rst      : 100 MHz clock, async active-high reset
//   scl_i, sda_i  : bus inputs
//   sda_oe, scl_oe: open-drain pull-down enables (1 = drive low)
//   temp_in       : 13-bit two's-complement temperature, 4 fractional bits
//   cfg_reg       : configuration register 0x03
//   busy          : address-matched transaction in progress (until STOP)
//   dbg_state_o   : current FSM state
//
// Bus handshake: every bit is a valid/ready exchange on SCL -- data is launched
// only after an SCL fall and is taken by the receiver on the following SCL rise.
module tmp_i2c_responder
  import tmp_resp_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEFAULT_ADDR,
  parameter logic [7:0] ID_VAL      = 8'hCB,
  parameter int         STRETCH_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        scl_oe,
  input  logic [12:0] temp_in,
  output logic [7:0]  cfg_reg,
  output logic        busy,
  output tmp_state_e  dbg_state_o
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_sync_edge u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (sda_s),
    .scl_rise_o(scl_rise),
    .scl_fall_o(scl_fall),
    .start_o   (start_det),
    .stop_o    (stop_det)
  );

  tmp_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  cfg_q, cfg_d;
  logic [12:0] snap_q, snap_d;
  logic        first_q, first_d;
  logic        rw_q, rw_d;
  logic        busy_q, busy_d;
  logic        sda_oe_q, sda_oe_d;
  logic        load_stretch;
  logic [7:0]  rd_data;

  // Read mux uses the snapshot so MSB/LSB bytes of one read come from the same sample.
  always_comb begin
    rd_data = 8'h00;
    case (ptr_q)
      REG_TMSB: rd_data = snap_q[12:5];
      REG_TLSB: rd_data = {snap_q[4:0], 3'b000};
      REG_STAT: rd_data = 8'h00;
      REG_CFG:  rd_data = cfg_q;
      REG_ID:   rd_data = ID_VAL;
      default:  rd_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    tx_d         = tx_q;
    ptr_d        = ptr_q;
    cfg_d        = cfg_q;
    snap_d       = snap_q;
    first_d      = first_q;
    rw_d         = rw_q;
    busy_d       = busy_q;
    sda_oe_d     = sda_oe_q;
    load_stretch = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      // Any START (incl. repeated, or mid-byte) restarts address reception;
      // a partially received write byte is simply dropped.
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: sda_oe_d = 1'b0;

        ADDR: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            if (shreg_q[7:1] == DEV_ADDR) begin
              state_d  = ADDR_ACK;
              sda_oe_d = 1'b1;
              rw_d     = shreg_q[0];
              snap_d   = temp_in;
              busy_d   = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              state_d  = RD_BYTE;
              tx_d     = rd_data;
              ptr_d    = ptr_q + 8'd1;
              sda_oe_d = ~rd_data[7];
            end else begin
              state_d  = WR_BYTE;
              sda_oe_d = 1'b0;
              first_d  = 1'b1;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            state_d  = WR_ACK;
            sda_oe_d = 1'b1;
            if (first_q) begin
              ptr_d   = shreg_q;
              first_d = 1'b0;
            end else begin
              // Only cfg is writable; other addresses are ACKed but ignored.
              if (ptr_q == REG_CFG) cfg_d = shreg_q;
              ptr_d = ptr_q + 8'd1;
            end
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            state_d   = WR_BYTE;
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
          end
        end

        RD_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd7) begin
              state_d  = RD_ACK;
              sda_oe_d = 1'b0;
            end else begin
              tx_d      = {tx_q[6:0], 1'b0};
              sda_oe_d  = ~tx_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end

        RD_ACK: begin
          sda_oe_d = 1'b0;
          if (scl_rise && sda_s) begin
            state_d = IDLE;
          end else if (scl_fall) begin
            // Only reachable after an ACK rise: preload next byte's MSB.
            state_d      = RD_BYTE;
            tx_d         = rd_data;
            ptr_d        = ptr_q + 8'd1;
            sda_oe_d     = ~rd_data[7];
            bit_cnt_d    = 4'd0;
            load_stretch = 1'b1;
          end
        end

        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 8'h00;
      tx_q      <= 8'h00;
      ptr_q     <= 8'h00;
      cfg_q     <= 8'h00;
      snap_q    <= 13'h0000;
      first_q   <= 1'b0;
      rw_q      <= 1'b0;
      busy_q    <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      ptr_q     <= ptr_d;
      cfg_q     <= cfg_d;
      snap_q    <= snap_d;
      first_q   <= first_d;
      rw_q      <= rw_d;
      busy_q    <= busy_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

`ifdef TMP_RESP_STRETCH_EN
  logic [15:0] stretch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   stretch_q <= 16'd0;
    else if (load_stretch)     stretch_q <= 16'(STRETCH_CYC);
    else if (stretch_q != 0)   stretch_q <= stretch_q - 16'd1;
  end

  assign scl_oe = (stretch_q != 16'd0);
`else
  logic unused_stretch;
  assign unused_stretch = load_stretch ^ (STRETCH_CYC != 0);
  assign scl_oe = 1'b0;
`endif

  assign sda_oe      = sda_oe_q;
  assign cfg_reg     = cfg_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_tmp_i2c_responder.sv
module tb_tmp_i2c_responder;
  import tmp_resp_pkg::*;

  localparam int Q = 20;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        scl_bus, sda_bus;
  logic        sda_oe, scl_oe, busy;
  logic [12:0] temp_in = 13'h0000;
  logic [7:0]  cfg_reg;
  tmp_state_e  dbg_state;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   rd_acks = 0;
  int   scl_oe_cycles = 0;
  logic sda_oe_seen = 1'b0;

  assign scl_bus = m_scl & ~scl_oe;
  assign sda_bus = m_sda & ~sda_oe;

  tmp_i2c_responder dut (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (scl_bus),
    .sda_i      (sda_bus),
    .sda_oe     (sda_oe),
    .scl_oe     (scl_oe),
    .temp_in    (temp_in),
    .cfg_reg    (cfg_reg),
    .busy       (busy),
    .dbg_state_o(dbg_state)
  );

  always @(negedge clk) begin
    if (scl_oe) scl_oe_cycles++;
    if (sda_oe) sda_oe_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks (all bus changes happen on negedge, away from the sampling edge)
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_release;
    int budget;
    m_scl = 1'b1;
    budget = 0;
    while (scl_bus !== 1'b1 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 1000) begin
      tests_run++; tests_failed++;
      $display("FAIL scl_release: SCL held low for %0d cycles, limit 1000", budget);
    end
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; wait_clks(Q);
    scl_release;  wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    m_scl = 1'b0; wait_clks(4);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; wait_clks(Q);
    scl_release;  wait_clks(Q);
    m_sda = 1'b1; wait_clks(Q);
  endtask

  task automatic clock_bit(input logic b, output logic sampled);
    m_sda = b; wait_clks(Q);
    scl_release; wait_clks(Q / 2);
    sampled = sda_bus;
    wait_clks(Q / 2);
    m_scl = 1'b0; wait_clks(4);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked, output logic early);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], s);
    early = sda_oe;  // 4 clk after the SCL fall that ends bit 8
    clock_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic recv_byte(input logic ack_bit, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clock_bit(ack_bit, s);
    if (!ack_bit) rd_acks++;
  endtask

  // scenarios
  task automatic test_reset;
    rst = 1'b1;
    wait_clks(3);
    tests_run++; if (sda_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_sda_oe: got %b exp 0", sda_oe); end
    tests_run++; if (scl_oe !== 1'b0) begin tests_failed++; $display("FAIL reset_scl_oe: got %b exp 0", scl_oe); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b exp 0", busy); end
    tests_run++; if (cfg_reg !== 8'h00) begin tests_failed++; $display("FAIL reset_cfg: got %h exp 00", cfg_reg); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, IDLE); end
    rst = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_id_read;
    logic a1, e1, a2, e2, a3, e3;
    logic [7:0] d;
    i2c_start;
    send_byte(8'h96, a1, e1);
    send_byte(8'h0B, a2, e2);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL id_busy: got %b exp 1", busy); end
    i2c_start;
    send_byte(8'h97, a3, e3);
    recv_byte(1'b1, d);
    i2c_stop;
    wait_clks(5);
    tests_run++; if ({a1, a2, a3} !== 3'b111) begin tests_failed++; $display("FAIL id_acks: got %b exp 111", {a1, a2, a3}); end
    tests_run++; if ({e1, e2, e3} !== 3'b111) begin tests_failed++; $display("FAIL id_ack_latency: got %b exp 111", {e1, e2, e3}); end
    tests_run++; if (d !== 8'hCB) begin tests_failed++; $display("FAIL id_data: got %h exp cb", d); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL id_busy_after_stop: got %b exp 0", busy); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL id_state_after_stop: got %0d exp %0d", dbg_state, IDLE); end
  endtask

  task automatic test_temp_read;
    logic a1, a2, a3, e;
    logic [7:0] d0, d1;
    temp_in = 13'h0190;
    i2c_start; send_byte(8'h96, a1, e); send_byte(8'h00, a2, e); i2c_stop;
    i2c_start; send_byte(8'h97, a3, e);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    i2c_stop;
    tests_run++; if ({a1, a2, a3} !== 3'b111) begin tests_failed++; $display("FAIL temp_acks: got %b exp 111", {a1, a2, a3}); end
    tests_run++; if (d0 !== 8'h0C) begin tests_failed++; $display("FAIL temp_msb: got %h exp 0c", d0); end
    tests_run++; if (d1 !== 8'h80) begin tests_failed++; $display("FAIL temp_lsb: got %h exp 80", d1); end
  endtask

  task automatic test_snapshot;
    logic a, e;
    logic [7:0] d0, d1;
    temp_in = 13'h1F80;
    i2c_start; send_byte(8'h96, a, e); send_byte(8'h00, a, e);
    i2c_start; send_byte(8'h97, a, e);
    recv_byte(1'b0, d0);
    temp_in = 13'h0190;
    recv_byte(1'b1, d1);
    i2c_stop;
    tests_run++; if (d0 !== 8'hFC) begin tests_failed++; $display("FAIL snap_msb: got %h exp fc", d0); end
    tests_run++; if (d1 !== 8'h00) begin tests_failed++; $display("FAIL snap_lsb: got %h exp 00", d1); end
  endtask

  task automatic test_cfg_write;
    logic a1, a2, a3, e;
    logic [7:0] d;
    i2c_start; send_byte(8'h96, a1, e); send_byte(8'h03, a2, e); send_byte(8'hA0, a3, e); i2c_stop;
    tests_run++; if ({a1, a2, a3} !== 3'b111) begin tests_failed++; $display("FAIL cfg_acks: got %b exp 111", {a1, a2, a3}); end
    tests_run++; if (cfg_reg !== 8'hA0) begin tests_failed++; $display("FAIL cfg_reg: got %h exp a0", cfg_reg); end
    i2c_start; send_byte(8'h96, a1, e); send_byte(8'h03, a1, e);
    i2c_start; send_byte(8'h97, a1, e);
    recv_byte(1'b1, d);
    i2c_stop;
    tests_run++; if (d !== 8'hA0) begin tests_failed++; $display("FAIL cfg_readback: got %h exp a0", d); end
  endtask

  task automatic test_ptr_wrap;
    logic a1, a2, a3, a4, e;
    logic [7:0] d0, d1, d2;
    // pointer 0xFF -> reads 0xFF (00) then wraps to 0x00 (temp MSB, temp_in = 0x0190)
    i2c_start; send_byte(8'h96, a1, e); send_byte(8'hFF, a1, e);
    i2c_start; send_byte(8'h97, a1, e);
    recv_byte(1'b0, d0);
    recv_byte(1'b1, d1);
    i2c_stop;
    tests_run++; if (d0 !== 8'h00) begin tests_failed++; $display("FAIL wrap_ff: got %h exp 00", d0); end
    tests_run++; if (d1 !== 8'h0C) begin tests_failed++; $display("FAIL wrap_00: got %h exp 0c", d1); end
    // writes to 0xFF and 0x00 are ACKed but ignored; pointer ends at 0x01
    i2c_start; send_byte(8'h96, a1, e); send_byte(8'hFF, a2, e);
    send_byte(8'h5A, a3, e); send_byte(8'h33, a4, e); i2c_stop;
    tests_run++; if ({a1, a2, a3, a4} !== 4'b1111) begin tests_failed++; $display("FAIL ignored_write_acks: got %b exp 1111", {a1, a2, a3, a4}); end
    tests_run++; if (cfg_reg !== 8'hA0) begin tests_failed++; $display("FAIL ignored_write_cfg: got %h exp a0", cfg_reg); end
    // pointer persists across transactions
    i2c_start; send_byte(8'h97, a1, e);
    recv_byte(1'b1, d2);
    i2c_stop;
    tests_run++; if (d2 !== 8'h80) begin tests_failed++; $display("FAIL ptr_persist: got %h exp 80", d2); end
  endtask

  task automatic test_nack_addr;
    logic a, e;
    i2c_start;
    sda_oe_seen = 1'b0;
    send_byte(8'h94, a, e);
    tests_run++; if (a !== 1'b0) begin tests_failed++; $display("FAIL nack_addr_ack: got %b exp 0", a); end
    tests_run++; if (sda_oe_seen !== 1'b0) begin tests_failed++; $display("FAIL nack_addr_sda_oe: got %b exp 0", sda_oe_seen); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL nack_addr_busy: got %b exp 0", busy); end
    i2c_stop;
  endtask

  task automatic test_abort;
    logic a, e, s;
    i2c_start; send_byte(8'h96, a, e); send_byte(8'h03, a, e);
    clock_bit(1'b0, s); clock_bit(1'b0, s); clock_bit(1'b0, s); clock_bit(1'b1, s);
    i2c_start;
    i2c_stop;
    wait_clks(5);
    tests_run++; if (cfg_reg !== 8'hA0) begin tests_failed++; $display("FAIL abort_cfg: got %h exp a0", cfg_reg); end
    tests_run++; if (dbg_state !== IDLE) begin tests_failed++; $display("FAIL abort_state: got %0d exp %0d", dbg_state, IDLE); end
  endtask

  task automatic test_rst_midread;
    logic a, e, s;
    logic [7:0] d;
    i2c_start; send_byte(8'h96, a, e); send_byte(8'h0B, a, e);
    i2c_start; send_byte(8'h97, a, e);
    clock_bit(1'b1, s); clock_bit(1'b1, s);  // ID 0xCB: bits 7,6 = 1, bit 5 = 0 now driven
    tests_run++; if (sda_oe !== 1'b1) begin tests_failed++; $display("FAIL midread_driving: got %b exp 1", sda_oe); end
    #2;
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    #1;
    tests_run++; if (sda_oe !== 1'b0) begin tests_failed++; $display("FAIL rst_async_sda_oe: got %b exp 0", sda_oe); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b exp 0", busy); end
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    tests_run++; if (cfg_reg !== 8'h00) begin tests_failed++; $display("FAIL rst_cfg_cleared: got %h exp 00", cfg_reg); end
    // pointer back to 0x00 -> temp MSB (temp_in = 0x0190)
    i2c_start; send_byte(8'h97, a, e);
    recv_byte(1'b1, d);
    i2c_stop;
    tests_run++; if (d !== 8'h0C) begin tests_failed++; $display("FAIL rst_ptr_cleared: got %h exp 0c", d); end
  endtask

  task automatic test_stretch;
    int exp_cycles;
`ifdef TMP_RESP_STRETCH_EN
    exp_cycles = rd_acks * 16;
`else
    exp_cycles = 0;
`endif
    tests_run++;
    if (scl_oe_cycles !== exp_cycles) begin
      tests_failed++;
      $display("FAIL scl_oe_cycles: got %0d exp %0d (acked read bytes %0d)", scl_oe_cycles, exp_cycles, rd_acks);
    end
  endtask

  initial begin
    test_reset;
    test_id_read;
    test_temp_read;
    test_snapshot;
    test_cfg_write;
    test_ptr_wrap;
    test_nack_addr;
    test_abort;
    test_rst_midread;
    test_stretch;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
